muu_packet_framer512: RTL and testbench

- Sits directly upstream of the multi-op request splitter (muu_RequestSplit512).
- Joins a per-packet 64-bit network-metadata stream with the 512-bit payload stream into one 576-bit stream, and attaches a user ID to each beat.
- Enforces that every packet is exactly 2+loadlen beats long, so the splitter's state machine can never desynchronise: short packets are zero-padded, long packets are truncated, oversize packets are dropped.

---
 rtl/muu_frame_pkg.sv | 15 +
 rtl/muu_axis_outreg576.sv | 39 +++
 rtl/muu_packet_framer512.sv | 163 ++++++++++++++++
 tb/tb_muu_packet_framer512.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muu_frame_pkg.sv
// rtl/muu_frame_pkg.sv - shared header offsets, state encoding and framing constants
package muu_frame_pkg;

  localparam int LOADLEN_LSB = 32;
  localparam int OPCODE_LSB  = 24;
  localparam int HDR_BEATS   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    PAD  = 2'd2,
    DROP = 2'd3
  } state_t;

endpackage

// File: rtl/muu_axis_outreg576.sv
// rtl/muu_axis_outreg576.sv - single-entry 576-bit output register with valid/ready
module muu_axis_outreg576 #(
  parameter int USER_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [575:0]         load_data,
  input  logic [USER_BITS-1:0] load_user,
  input  logic                 load_last,
  output logic [575:0]         tdata,
  output logic                 tvalid,
  output logic [USER_BITS-1:0] tuserid,
  output logic                 tlast,
  input  logic                 tready,
  output logic                 oe
);

  assign oe = !tvalid || tready;

  // load is only raised while oe, so a held beat is never overwritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid  <= 1'b0;
      tdata   <= '0;
      tuserid <= '0;
      tlast   <= 1'b0;
    end else if (load) begin
      tvalid  <= 1'b1;
      tdata   <= load_data;
      tuserid <= load_user;
      tlast   <= load_last;
    end else if (tready) begin
      tvalid  <= 1'b0;
      tlast   <= 1'b0;
    end
  end

endmodule

// File: rtl/muu_packet_framer512.sv
// rtl/muu_packet_framer512.sv - joins net-meta with payload and forces every packet to loadlen+2 beats
module muu_packet_framer512
  import muu_frame_pkg::*;
#(
  parameter int          USER_BITS = 3,
  parameter int          USER_LSB  = 0,
  parameter logic [15:0] MAX_LOAD  = 16'd1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          s_meta_tdata,
  input  logic                 s_meta_tvalid,
  output logic                 s_meta_tready,
  input  logic [511:0]         s_data_tdata,
  input  logic                 s_data_tvalid,
  input  logic                 s_data_tlast,
  output logic                 s_data_tready,
  output logic [575:0]         m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic [USER_BITS-1:0] m_axis_tuserid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [31:0]          stat_pkts,
  output logic [31:0]          stat_pad,
  output logic [31:0]          stat_trunc,
  output logic [31:0]          stat_drop
);

  state_t                state, next_state;
  logic [16:0]           cnt, exp_len;
  logic [63:0]           meta;
  logic [USER_BITS-1:0]  user;
  logic                  oe, load, load_last;
  logic [575:0]          load_data;
  logic [USER_BITS-1:0]  load_user;
  logic                  cnt_set, cnt_inc;
  logic                  inc_pkts, inc_pad, inc_trunc, inc_drop;
  logic [15:0]           hdr_len;
  logic                  oversize, at_last;

  assign hdr_len  = s_data_tdata[LOADLEN_LSB +: 16];
  assign oversize = hdr_len > MAX_LOAD;
  assign at_last  = (cnt == exp_len - 17'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (s_meta_tvalid && s_data_tvalid && oe) begin
        if (oversize) next_state = s_data_tlast ? IDLE : DROP;
        else          next_state = s_data_tlast ? PAD : BODY;
      end
      BODY: if (s_data_tvalid && oe) begin
        if (at_last)           next_state = s_data_tlast ? IDLE : DROP;
        else if (s_data_tlast) next_state = PAD;
      end
      PAD:  if (oe && at_last) next_state = IDLE;
      DROP: if (s_data_tvalid && s_data_tlast) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // rst gates the IDLE readies so upstream sees no handshake while held in reset
  always_comb begin
    s_meta_tready = 1'b0;
    s_data_tready = 1'b0;
    load          = 1'b0;
    load_data     = {meta, s_data_tdata};
    load_user     = user;
    load_last     = 1'b0;
    cnt_set       = 1'b0;
    cnt_inc       = 1'b0;
    inc_pkts      = 1'b0;
    inc_pad       = 1'b0;
    inc_trunc     = 1'b0;
    inc_drop      = 1'b0;
    case (state)
      IDLE: if (rst && s_meta_tvalid && oe) begin
        s_data_tready = 1'b1;
        if (s_data_tvalid) begin
          s_meta_tready = 1'b1;
          if (oversize) begin
            inc_drop = 1'b1;
          end else begin
            load      = 1'b1;
            load_data = {s_meta_tdata, s_data_tdata};
            load_user = s_meta_tdata[USER_LSB +: USER_BITS];
            cnt_set   = 1'b1;
            inc_pad   = s_data_tlast;
          end
        end
      end
      BODY: if (oe) begin
        s_data_tready = 1'b1;
        if (s_data_tvalid) begin
          load      = 1'b1;
          cnt_inc   = 1'b1;
          load_last = at_last;
          if (at_last) begin
            inc_pkts  = 1'b1;
            inc_trunc = !s_data_tlast;
          end else begin
            inc_pad = s_data_tlast;
          end
        end
      end
      PAD: if (oe) begin
        load      = 1'b1;
        load_data = {meta, 512'b0};
        cnt_inc   = 1'b1;
        load_last = at_last;
        inc_pkts  = at_last;
      end
      DROP: s_data_tready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      exp_len    <= '0;
      meta       <= '0;
      user       <= '0;
      stat_pkts  <= '0;
      stat_pad   <= '0;
      stat_trunc <= '0;
      stat_drop  <= '0;
    end else begin
      if (s_meta_tready) begin
        meta    <= s_meta_tdata;
        user    <= s_meta_tdata[USER_LSB +: USER_BITS];
        exp_len <= {1'b0, hdr_len} + 17'(HDR_BEATS);
      end
      if (cnt_set)      cnt <= 17'd1;
      else if (cnt_inc) cnt <= cnt + 17'd1;
      if (inc_pkts)  stat_pkts  <= stat_pkts + 32'd1;
      if (inc_pad)   stat_pad   <= stat_pad + 32'd1;
      if (inc_trunc) stat_trunc <= stat_trunc + 32'd1;
      if (inc_drop)  stat_drop  <= stat_drop + 32'd1;
    end
  end

  muu_axis_outreg576 #(.USER_BITS(USER_BITS)) u_outreg (
    .clk       (clk),
    .rst_n     (rst),
    .load      (load),
    .load_data (load_data),
    .load_user (load_user),
    .load_last (load_last),
    .tdata     (m_axis_tdata),
    .tvalid    (m_axis_tvalid),
    .tuserid   (m_axis_tuserid),
    .tlast     (m_axis_tlast),
    .tready    (m_axis_tready),
    .oe        (oe)
  );

endmodule

// File: tb/tb_muu_packet_framer512.sv
// tb/tb_muu_packet_framer512.sv - scoreboard bench for muu_packet_framer512
module tb_muu_packet_framer512;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  s_meta_tdata;
  logic         s_meta_tvalid, s_meta_tready;
  logic [511:0] s_data_tdata;
  logic         s_data_tvalid, s_data_tlast, s_data_tready;
  logic [575:0] m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [2:0]   m_axis_tuserid;
  logic [31:0]  stat_pkts, stat_pad, stat_trunc, stat_drop;

  always #5 clk = ~clk;

  muu_packet_framer512 #(.USER_BITS(3), .USER_LSB(0), .MAX_LOAD(16'd8)) dut (
    .clk(clk), .rst(rst_n),
    .s_meta_tdata(s_meta_tdata), .s_meta_tvalid(s_meta_tvalid), .s_meta_tready(s_meta_tready),
    .s_data_tdata(s_data_tdata), .s_data_tvalid(s_data_tvalid), .s_data_tlast(s_data_tlast),
    .s_data_tready(s_data_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tuserid(m_axis_tuserid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .stat_pkts(stat_pkts), .stat_pad(stat_pad), .stat_trunc(stat_trunc), .stat_drop(stat_drop)
  );

  typedef logic [579:0] beat_t;   // {last, user, meta, payload}

  int          tests_run = 0;
  int          failed = 0;
  beat_t       sb[$];
  logic [63:0] mq[$];
  logic [512:0] dq[$];
  int          stamps[$];
  int          meta_pops = 0, data_beats = 0, cyc = 0;
  bit          bp = 1'b0;
  logic [31:0] e_pkts = 0, e_pad = 0, e_trunc = 0, e_drop = 0;
  bit          stall_prev = 1'b0;
  beat_t       held;

  always @(posedge clk) cyc++;

  // stream driver: presents queue heads, pops after each observed handshake
  initial begin
    logic mh, dh;
    logic [63:0] tm;
    logic [512:0] td;
    s_meta_tvalid = 1'b0; s_meta_tdata = '0;
    s_data_tvalid = 1'b0; s_data_tdata = '0; s_data_tlast = 1'b0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      mh = s_meta_tvalid && s_meta_tready;
      dh = s_data_tvalid && s_data_tready;
      @(posedge clk); #1;
      if (mh && mq.size() > 0) begin tm = mq.pop_front(); meta_pops++; end
      if (dh && dq.size() > 0) begin td = dq.pop_front(); data_beats++; end
      s_meta_tvalid = (mq.size() > 0);
      s_meta_tdata  = (mq.size() > 0) ? mq[0] : 64'd0;
      td = (dq.size() > 0) ? dq[0] : '0;
      s_data_tvalid = (dq.size() > 0);
      s_data_tlast  = td[512];
      s_data_tdata  = td[511:0];
      m_axis_tready = bp ? !m_axis_tready : 1'b1;
    end
  end

  // output monitor: scoreboard compare and hold-while-stalled check
  always @(negedge clk) begin
    beat_t obs, e;
    obs = {m_axis_tlast, m_axis_tuserid, m_axis_tdata};
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        tests_run++;
        if (!m_axis_tvalid || obs !== held) begin
          failed++;
          $display("FAIL stall_hold: got v=%0b %h, required v=1 %h", m_axis_tvalid, obs, held);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        stamps.push_back(cyc);
        tests_run++;
        if (sb.size() == 0) begin
          failed++;
          $display("FAIL unexpected_beat: got %h, required no beat", obs);
        end else begin
          e = sb.pop_front();
          if (obs !== e) begin
            failed++;
            $display("FAIL beat: got %h, required %h", obs, e);
          end
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held = obs;
    end
  end

  task automatic push_pkt(input logic [63:0] m, input logic [15:0] len, input int n, input bit with_meta);
    logic [511:0] b;
    int e;
    e = int'(len) + 2;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 16; j++) b[j*32 +: 32] = $urandom();
      if (i == 0) begin b[47:32] = len; b[31:24] = 8'h5A; end
      dq.push_back({(i == n-1), b});
      if (len <= 16'd8 && i < e) sb.push_back({(i == e-1), m[2:0], m, b});
    end
    if (len <= 16'd8) begin
      for (int i = n; i < e; i++) sb.push_back({(i == e-1), m[2:0], m, 512'b0});
      e_pkts++;
      if (n < e) e_pad++;
      if (n > e) e_trunc++;
    end else begin
      e_drop++;
    end
    if (with_meta) mq.push_back(m);
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && dq.size() == 0 && mq.size() == 0 && !m_axis_tvalid) break;
    end
    tests_run++;
    if (k == 400) begin
      failed++;
      $display("FAIL %s_drain: got sb=%0d dq=%0d mq=%0d, required all empty", name, sb.size(), dq.size(), mq.size());
    end
    @(negedge clk);
  endtask

  task automatic check_stats(input string name);
    tests_run++;
    if ({stat_pkts, stat_pad, stat_trunc, stat_drop} !== {e_pkts, e_pad, e_trunc, e_drop}) begin
      failed++;
      $display("FAIL %s_stats: got %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d", name,
               stat_pkts, stat_pad, stat_trunc, stat_drop, e_pkts, e_pad, e_trunc, e_drop);
    end
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuserid, m_axis_tdata, s_meta_tready, s_data_tready} !== '0 ||
        {stat_pkts, stat_pad, stat_trunc, stat_drop} !== 128'd0) begin
      failed++;
      $display("FAIL reset_state: got v=%0b l=%0b stats=%0d/%0d/%0d/%0d, required all 0",
               m_axis_tvalid, m_axis_tlast, stat_pkts, stat_pad, stat_trunc, stat_drop);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exact();
    int mp, db;
    mp = meta_pops; db = data_beats;
    push_pkt(64'hAB, 16'd3, 5, 1'b1);
    wait_drain("exact");
    check_stats("exact");
    tests_run++;
    if (meta_pops - mp != 1 || data_beats - db != 5) begin
      failed++;
      $display("FAIL exact_consumed: got meta=%0d data=%0d, required meta=1 data=5", meta_pops - mp, data_beats - db);
    end
  endtask

  task automatic test_short();
    push_pkt(64'h1234_5678_0000_00C5, 16'd4, 3, 1'b1);
    wait_drain("short");
    check_stats("short");
  endtask

  task automatic test_long();
    int db;
    db = data_beats;
    push_pkt(64'hDEAD_BEEF_0000_0016, 16'd1, 6, 1'b1);
    push_pkt(64'h0000_0000_0000_0107, 16'd2, 4, 1'b1);
    wait_drain("long");
    check_stats("long");
    tests_run++;
    if (data_beats - db != 10) begin
      failed++;
      $display("FAIL long_consumed: got %0d, required 10", data_beats - db);
    end
  endtask

  task automatic test_oversize();
    int mp, db;
    mp = meta_pops; db = data_beats;
    push_pkt(64'hFACE_0000_0000_0042, 16'd9, 11, 1'b1);
    wait_drain("oversize");
    check_stats("oversize");
    tests_run++;
    if (meta_pops - mp != 1 || data_beats - db != 11) begin
      failed++;
      $display("FAIL oversize_consumed: got meta=%0d data=%0d, required meta=1 data=11", meta_pops - mp, data_beats - db);
    end
  endtask

  task automatic test_back_to_back();
    bp = 1'b1;
    push_pkt(64'h0000_0000_0000_1111, 16'd0, 2, 1'b1);
    push_pkt(64'h0000_0000_0000_2222, 16'd0, 2, 1'b1);
    wait_drain("bp");
    check_stats("bp");
    bp = 1'b0;
    repeat (2) @(negedge clk);
    stamps.delete();
    push_pkt(64'h0000_0000_0000_3333, 16'd0, 2, 1'b1);
    push_pkt(64'h0000_0000_0000_4444, 16'd0, 2, 1'b1);
    wait_drain("b2b");
    tests_run++;
    if (stamps.size() != 4 || stamps[3] - stamps[0] != 3) begin
      failed++;
      $display("FAIL b2b_throughput: got %0d beats span %0d, required 4 beats span 3",
               stamps.size(), (stamps.size() == 4) ? stamps[3] - stamps[0] : -1);
    end
    check_stats("b2b");
  endtask

  task automatic test_starve_reset();
    bit seen;
    int db, k;
    seen = 1'b0;
    push_pkt(64'h0000_0000_0000_0055, 16'd4, 5, 1'b0);
    repeat (6) begin
      @(negedge clk);
      if (s_data_tready) seen = 1'b1;
    end
    tests_run++;
    if (seen || data_beats != 0 && dq.size() != 5) begin
      failed++;
      $display("FAIL starve_ready: got ready_seen=%0b dq=%0d, required 0 and 5", seen, dq.size());
    end
    db = data_beats;
    mq.push_back(64'h0000_0000_0000_0055);
    for (k = 0; k < 100 && data_beats - db < 2; k++) @(negedge clk);
    tests_run++;
    if (k == 100) begin
      failed++;
      $display("FAIL starve_progress: got %0d beats, required 2", data_beats - db);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuserid, m_axis_tdata, s_meta_tready, s_data_tready} !== '0 ||
        {stat_pkts, stat_pad, stat_trunc, stat_drop} !== 128'd0) begin
      failed++;
      $display("FAIL midpkt_reset: got v=%0b l=%0b stats=%0d/%0d/%0d/%0d, required all 0",
               m_axis_tvalid, m_axis_tlast, stat_pkts, stat_pad, stat_trunc, stat_drop);
    end
    sb.delete(); dq.delete(); mq.delete();
    e_pkts = 0; e_pad = 0; e_trunc = 0; e_drop = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_pkt(64'h0000_0000_0000_00E6, 16'd1, 3, 1'b1);
    wait_drain("after_reset");
    check_stats("after_reset");
  endtask

  initial begin
    test_reset();
    test_exact();
    test_short();
    test_long();
    test_oversize();
    test_back_to_back();
    test_starve_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
